// File: rtl/ptp_rx_pkg.sv
// -----------------------------------------------------------------------------
// ptp_rx_pkg
// Shared types and constants for the receive-side PTP frame parser:
//   - parse_state_e : header-walk states
//   - transport_e   : result transport codes (L2 / IPv4 / IPv6)
//   - ET_*          : Ethertypes recognised by the parser
//   - IP_PROTO_UDP  : IPv4 protocol / IPv6 next-header value for UDP
//   - parse_ctx_t   : per-frame parse context held in the parser
// -----------------------------------------------------------------------------
package ptp_rx_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_MAC,
    S_ETYPE,
    S_VLAN,
    S_MPLS,
    S_IPV4,
    S_IPV6,
    S_UDP,
    S_PTP,
    S_SKIP
  } parse_state_e;

  typedef enum logic [1:0] {
    TR_L2   = 2'd0,
    TR_IPV4 = 2'd1,
    TR_IPV6 = 2'd2
  } transport_e;

  localparam logic [15:0] ET_VLAN    = 16'h8100;
  localparam logic [15:0] ET_QINQ    = 16'h88A8;
  localparam logic [15:0] ET_MPLS_UC = 16'h8847;
  localparam logic [15:0] ET_MPLS_MC = 16'h8848;
  localparam logic [15:0] ET_IPV4    = 16'h0800;
  localparam logic [15:0] ET_IPV6    = 16'h86DD;
  localparam logic [15:0] ET_PTP     = 16'h88F7;

  localparam logic [7:0] IP_PROTO_UDP = 8'h11;

  // Everything the parser remembers about the frame in flight, except the
  // capture shift register whose width depends on a module parameter.
  typedef struct packed {
    parse_state_e state;
    logic [15:0]  cnt;        // byte index within the current state
    logic [7:0]   vlan_cnt;   // tags seen so far
    logic [7:0]   byte_hold;  // high byte of a 16-bit field (Ethertype, UDP port)
    logic [5:0]   hdr_len;    // IPv4 header length in bytes
    logic         hdr_ok;     // IP header carries UDP
    logic         mpls_bos;   // current MPLS label has the S bit set
    transport_e   transport;
    logic [3:0]   msg_type;
    logic         cap_done;
    logic         l2_en;      // transport enables latched at rx_sof
    logic         ipv4_en;
    logic         ipv6_en;
  } parse_ctx_t;

endpackage

// File: rtl/ptp_rx_parser_p_if.sv
// -----------------------------------------------------------------------------
// ptp_rx_parser_p_if
// Bundles the receive byte stream and the result valid/ready channel.
//   slave  : the parser (consumes rx_*, produces res_*, sees res_ready)
//   master : the environment (MAC receive path + timestamp logic)
// -----------------------------------------------------------------------------
interface ptp_rx_parser_p_if #(
  parameter int CAP_BYTES = 12
);

  logic                   rx_valid;
  logic                   rx_sof;
  logic                   rx_eof;
  logic                   rx_err;
  logic [7:0]             rx_data;

  logic                   res_valid;
  logic                   res_ready;
  logic [3:0]             res_msg_type;
  logic [1:0]             res_transport;
  logic [8*CAP_BYTES-1:0] res_cap;

  modport slave (
    input  rx_valid, rx_sof, rx_eof, rx_err, rx_data, res_ready,
    output res_valid, res_msg_type, res_transport, res_cap
  );

  modport master (
    output rx_valid, rx_sof, rx_eof, rx_err, rx_data, res_ready,
    input  res_valid, res_msg_type, res_transport, res_cap
  );

endinterface

// File: rtl/ptp_res_fifo.sv
// -----------------------------------------------------------------------------
// ptp_res_fifo
// First-word fall-through result FIFO with overflow accounting.
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : write push_data this cycle (dropped when full and not popping)
//   pop        : consumer ready; pops the head when rd_valid
//   rd_valid   : head entry present
//   rd_data    : head entry (all zeros while empty)
//   ovf_pulse  : one-cycle pulse after an entry was dropped
//   drop_cnt   : saturating count of dropped entries
// -----------------------------------------------------------------------------
module ptp_res_fifo #(
  parameter int WIDTH = 102,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic             ovf_pulse,
  output logic [7:0]       drop_cnt
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             empty;
  logic             full;
  logic             do_pop;
  logic             do_push;
  logic             drop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop on the same edge frees the slot, so a push into a full FIFO survives.
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;

  assign rd_valid = !empty;
  assign rd_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ovf_pulse <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      ovf_pulse <= drop;
      if (drop && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  // NOTE: the storage array has no reset; only the pointers define which
  // entries are live, and rd_data is forced to zero while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/ptp_rx_parser_p.sv
// -----------------------------------------------------------------------------
// ptp_rx_parser_p
// Walks each received frame byte by byte (Ethernet, VLAN/QinQ tags, MPLS,
// IPv4/IPv6, UDP) and, for accepted PTP frames, queues messageType, transport
// and a window of PTP header bytes for the timestamp logic.
//   clk, rst_n          : byte clock, asynchronous active-low reset
//   bus (slave)         : rx byte stream in, res valid/ready channel out
//   cfg_l2_en/ipv4/ipv6 : transport enables, latched at rx_sof
//   ovf_pulse, drop_cnt : result-FIFO overflow reporting
// -----------------------------------------------------------------------------
module ptp_rx_parser_p #(
  parameter int          VLAN_MAX     = 2,
  parameter int          CAP_OFFSET   = 20,
  parameter int          CAP_BYTES    = 12,
  parameter int          FIFO_DEPTH   = 4,
  parameter logic [15:0] UDP_PORT_EV  = 16'd319,
  parameter logic [15:0] UDP_PORT_GEN = 16'd320
) (
  input  logic                    clk,
  input  logic                    rst_n,
  ptp_rx_parser_p_if.slave        bus,
  input  logic                    cfg_l2_en,
  input  logic                    cfg_ipv4_en,
  input  logic                    cfg_ipv6_en,
  output logic                    ovf_pulse,
  output logic [7:0]              drop_cnt
);

  import ptp_rx_pkg::*;

  localparam int          CAP_W     = 8 * CAP_BYTES;
  localparam int          ENTRY_W   = 6 + CAP_W;
  localparam logic [15:0] CAP_FIRST = 16'(CAP_OFFSET);
  localparam logic [15:0] CAP_LAST  = 16'(CAP_OFFSET + CAP_BYTES - 1);
  localparam logic [7:0]  VLAN_LIM  = 8'(VLAN_MAX);

  parse_ctx_t         ctx;
  parse_ctx_t         nxt;
  logic [CAP_W-1:0]   cap;
  logic [CAP_W-1:0]   cap_d;
  logic               push;
  logic [ENTRY_W-1:0] head;
  logic [15:0]        word;
  logic [15:0]        ipv4_last;
  logic               v4_ok;
  logic [5:0]         v4_len;

  // 16-bit field completed by the current byte (Ethertype or UDP port).
  assign word      = {ctx.byte_hold, bus.rx_data};
  assign ipv4_last = {10'd0, ctx.hdr_len} - 16'd1;
  // IPv4 first byte: version 4 and IHL >= 5; length is IHL*4 in 6 bits.
  assign v4_ok     = (bus.rx_data[7:4] == 4'h4) && (bus.rx_data[3:0] >= 4'd5);
  assign v4_len    = {bus.rx_data[3:0], 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctx <= '0;
      cap <= '0;
    end else begin
      ctx <= nxt;
      cap <= cap_d;
    end
  end

  // NOTE: every output of this block gets a default before any branch, so no
  // path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    nxt   = ctx;
    cap_d = cap;
    push  = 1'b0;
    if (bus.rx_valid) begin
      if (bus.rx_sof) begin
        // Start of frame always wins: any frame in flight is abandoned and
        // this byte is DA[0].
        nxt         = '0;
        nxt.state   = bus.rx_eof ? S_IDLE : S_MAC;
        nxt.cnt     = bus.rx_eof ? 16'd0 : 16'd1;
        nxt.l2_en   = cfg_l2_en;
        nxt.ipv4_en = cfg_ipv4_en;
        nxt.ipv6_en = cfg_ipv6_en;
        cap_d       = '0;
      end else if (bus.rx_eof) begin
        push      = (ctx.state == S_PTP) && ctx.cap_done && !bus.rx_err;
        nxt.state = S_IDLE;
        nxt.cnt   = '0;
      end else begin
        nxt.cnt = ctx.cnt + 16'd1;
        unique case (ctx.state)
          S_IDLE: nxt.cnt = '0;
          S_MAC: begin
            if (ctx.cnt == 16'd11) begin
              nxt.state = S_ETYPE;
              nxt.cnt   = '0;
            end
          end
          S_ETYPE: begin
            if (ctx.cnt == 16'd0) begin
              nxt.byte_hold = bus.rx_data;
            end else begin
              nxt.cnt = '0;
              case (word)
                ET_VLAN, ET_QINQ: begin
                  if (ctx.vlan_cnt < VLAN_LIM) begin
                    nxt.state    = S_VLAN;
                    nxt.vlan_cnt = ctx.vlan_cnt + 8'd1;
                  end else begin
                    nxt.state = S_SKIP;
                  end
                end
                ET_MPLS_UC, ET_MPLS_MC: begin
                  nxt.state    = S_MPLS;
                  nxt.mpls_bos = 1'b0;
                end
                ET_IPV4: begin
                  nxt.state     = ctx.ipv4_en ? S_IPV4 : S_SKIP;
                  nxt.transport = TR_IPV4;
                  nxt.hdr_ok    = 1'b0;
                end
                ET_IPV6: begin
                  nxt.state     = ctx.ipv6_en ? S_IPV6 : S_SKIP;
                  nxt.transport = TR_IPV6;
                  nxt.hdr_ok    = 1'b0;
                end
                ET_PTP: begin
                  nxt.state     = ctx.l2_en ? S_PTP : S_SKIP;
                  nxt.transport = TR_L2;
                end
                default: nxt.state = S_SKIP;
              endcase
            end
          end
          S_VLAN: begin
            if (ctx.cnt == 16'd1) begin
              nxt.state = S_ETYPE;
              nxt.cnt   = '0;
            end
          end
          S_MPLS: begin
            // Labels are 4 bytes; after the bottom label the counter runs on
            // to 4 so the first IP byte is inspected here and consumed.
            if (ctx.cnt == 16'd2) begin
              nxt.mpls_bos = bus.rx_data[0];
            end else if ((ctx.cnt == 16'd3) && !ctx.mpls_bos) begin
              nxt.cnt = '0;
            end else if (ctx.cnt == 16'd4) begin
              nxt.hdr_ok = 1'b0;
              if (v4_ok && ctx.ipv4_en) begin
                nxt.state     = S_IPV4;
                nxt.transport = TR_IPV4;
                nxt.hdr_len   = v4_len;
                nxt.cnt       = 16'd1;
              end else if ((bus.rx_data[7:4] == 4'h6) && ctx.ipv6_en) begin
                nxt.state     = S_IPV6;
                nxt.transport = TR_IPV6;
                nxt.cnt       = 16'd1;
              end else begin
                nxt.state = S_SKIP;
                nxt.cnt   = '0;
              end
            end
          end
          S_IPV4: begin
            if (ctx.cnt == 16'd0) begin
              if (v4_ok) begin
                nxt.hdr_len = v4_len;
              end else begin
                nxt.state = S_SKIP;
                nxt.cnt   = '0;
              end
            end else if (ctx.cnt == ipv4_last) begin
              // Options, if any, have been walked over by the counter.
              nxt.state = ctx.hdr_ok ? S_UDP : S_SKIP;
              nxt.cnt   = '0;
            end else if (ctx.cnt == 16'd9) begin
              nxt.hdr_ok = (bus.rx_data == IP_PROTO_UDP);
            end
          end
          S_IPV6: begin
            if (ctx.cnt == 16'd6) begin
              nxt.hdr_ok = (bus.rx_data == IP_PROTO_UDP);
            end else if (ctx.cnt == 16'd39) begin
              nxt.state = ctx.hdr_ok ? S_UDP : S_SKIP;
              nxt.cnt   = '0;
            end
          end
          S_UDP: begin
            if (ctx.cnt == 16'd2) begin
              nxt.byte_hold = bus.rx_data;
            end else if (ctx.cnt == 16'd3) begin
              if ((word != UDP_PORT_EV) && (word != UDP_PORT_GEN)) begin
                nxt.state = S_SKIP;
                nxt.cnt   = '0;
              end
            end else if (ctx.cnt == 16'd7) begin
              nxt.state = S_PTP;
              nxt.cnt   = '0;
            end
          end
          S_PTP: begin
            if (ctx.cap_done) begin
              nxt.cnt = ctx.cnt;
            end else begin
              if (ctx.cnt == 16'd0) nxt.msg_type = bus.rx_data[3:0];
              if ((ctx.cnt >= CAP_FIRST) && (ctx.cnt <= CAP_LAST))
                cap_d = (cap << 8) | CAP_W'(bus.rx_data);
              if (ctx.cnt == CAP_LAST) nxt.cap_done = 1'b1;
            end
          end
          S_SKIP: nxt.cnt = ctx.cnt;
          default: begin
            nxt.state = S_IDLE;
            nxt.cnt   = '0;
          end
        endcase
      end
    end
  end

  ptp_res_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({ctx.msg_type, ctx.transport, cap}),
    .pop       (bus.res_ready),
    .rd_valid  (bus.res_valid),
    .rd_data   (head),
    .ovf_pulse (ovf_pulse),
    .drop_cnt  (drop_cnt)
  );

  assign bus.res_msg_type  = head[ENTRY_W-1 -: 4];
  assign bus.res_transport = head[CAP_W +: 2];
  assign bus.res_cap       = head[CAP_W-1:0];

endmodule

// File: tb/tb_ptp_rx_parser_p.sv
// -----------------------------------------------------------------------------
// tb_ptp_rx_parser_p
// Directed bench for ptp_rx_parser_p: builds frames byte by byte, drives them
// on the falling edge and compares results against hand-derived values.
// -----------------------------------------------------------------------------
module tb_ptp_rx_parser_p;

  localparam int CAP_BYTES = 12;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_l2_en;
  logic       cfg_ipv4_en;
  logic       cfg_ipv6_en;
  logic       ovf_pulse;
  logic [7:0] drop_cnt;

  int checks = 0;
  int errors = 0;

  logic [7:0] frame_q[$];
  logic [7:0] tail_q[$];
  logic       pv;

  always #5 clk = ~clk;

  ptp_rx_parser_p_if #(.CAP_BYTES(CAP_BYTES)) bus ();

  ptp_rx_parser_p #(
    .VLAN_MAX     (2),
    .CAP_OFFSET   (20),
    .CAP_BYTES    (CAP_BYTES),
    .FIFO_DEPTH   (4),
    .UDP_PORT_EV  (16'd319),
    .UDP_PORT_GEN (16'd320)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.slave),
    .cfg_l2_en   (cfg_l2_en),
    .cfg_ipv4_en (cfg_ipv4_en),
    .cfg_ipv6_en (cfg_ipv6_en),
    .ovf_pulse   (ovf_pulse),
    .drop_cnt    (drop_cnt)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic add8(input logic [7:0] b);
    frame_q.push_back(b);
  endtask

  task automatic add16(input logic [15:0] w);
    frame_q.push_back(w[15:8]);
    frame_q.push_back(w[7:0]);
  endtask

  task automatic add_mac();
    add16(16'h011B); add16(16'h1900); add16(16'h0000);
    add16(16'h0011); add16(16'h2233); add16(16'h4455);
  endtask

  // 34-byte PTP header: byte0, filler, 12 bytes seed.. at 20..31, 2 trailing.
  task automatic add_ptp(input logic [7:0] b0, input logic [7:0] seed);
    add8(b0);
    for (int i = 1; i < 20; i++) add8(8'(i));
    for (int i = 0; i < 12; i++) add8(seed + 8'(i));
    add16(16'hEEEE);
  endtask

  // IPv4 with IHL = 6 (one NOP option word).
  task automatic add_ipv4(input logic [7:0] proto);
    add16(16'h4600); add16(16'h0046); add16(16'h1234); add16(16'h4000);
    add8(8'h40); add8(proto); add16(16'h0000);
    add16(16'hC0A8); add16(16'h0001); add16(16'hE000); add16(16'h0181);
    add16(16'h0101); add16(16'h0101);
  endtask

  task automatic add_ipv6();
    add16(16'h6000); add16(16'h0000); add16(16'h003A); add8(8'h11); add8(8'h40);
    for (int i = 0; i < 16; i++) add8(8'hA0 + 8'(i));
    for (int i = 0; i < 16; i++) add8(8'hB0 + 8'(i));
  endtask

  task automatic add_udp(input logic [15:0] dport);
    add16(dport); add16(dport); add16(16'h0036); add16(16'h0000);
  endtask

  task automatic add_mpls(input logic s);
    add8(8'h00); add8(8'h01); add8({7'd0, s}); add8(8'h40);
  endtask

  task automatic add_l2(input logic [7:0] b0, input logic [7:0] seed);
    add_mac(); add16(16'h88F7); add_ptp(b0, seed);
  endtask

  function automatic logic [95:0] exp_cap(input logic [7:0] seed);
    logic [95:0] v = '0;
    for (int i = 0; i < 12; i++) v = {v[87:0], seed + 8'(i)};
    return v;
  endfunction

  // Drives frame_q on falling edges. Returns at the falling edge after the
  // rising edge that sampled the last byte; pre_v is res_valid while the
  // last byte was presented.
  task automatic send(input logic sof, input logic eof, input logic err,
                      input int gap, input logic rdy_eof, output logic pre_v);
    int n;
    n = frame_q.size();
    pre_v = 1'b0;
    for (int i = 0; i < n; i++) begin
      bus.rx_valid = 1'b1;
      bus.rx_sof   = sof && (i == 0);
      bus.rx_eof   = eof && (i == n - 1);
      bus.rx_err   = err && (i == n - 1);
      bus.rx_data  = frame_q[i];
      if (i == n - 1) begin
        pre_v = bus.res_valid;
        if (rdy_eof) bus.res_ready = 1'b1;
      end
      @(negedge clk);
      if (rdy_eof && (i == n - 1)) bus.res_ready = 1'b0;
      if ((gap > 0) && (i != n - 1) && ((i % gap) == gap - 1)) begin
        // Stalled beat: qualifiers asserted but rx_valid low must be ignored.
        bus.rx_valid = 1'b0;
        bus.rx_sof   = 1'b1;
        bus.rx_eof   = 1'b1;
        bus.rx_err   = 1'b1;
        bus.rx_data  = 8'($urandom);
        @(negedge clk);
      end
    end
    bus.rx_valid = 1'b0;
    bus.rx_sof   = 1'b0;
    bus.rx_eof   = 1'b0;
    bus.rx_err   = 1'b0;
    frame_q.delete();
  endtask

  task automatic idle(input int n);
    bus.rx_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic pop_expect(input string tag, input logic [3:0] mt,
                            input logic [1:0] tr, input logic [95:0] cap);
    check({tag, "_valid"}, 128'(bus.res_valid), 128'(1'b1));
    check({tag, "_msg_type"}, 128'(bus.res_msg_type), 128'(mt));
    check({tag, "_transport"}, 128'(bus.res_transport), 128'(tr));
    check({tag, "_cap"}, 128'(bus.res_cap), 128'(cap));
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.rx_valid  = 1'b0;
    bus.rx_sof    = 1'b0;
    bus.rx_eof    = 1'b0;
    bus.rx_err    = 1'b0;
    bus.rx_data   = 8'h00;
    bus.res_ready = 1'b0;
    cfg_l2_en     = 1'b1;
    cfg_ipv4_en   = 1'b1;
    cfg_ipv6_en   = 1'b1;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_res_valid", 128'(bus.res_valid), 128'(1'b0));
    check("rst_msg_type", 128'(bus.res_msg_type), 128'(4'h0));
    check("rst_transport", 128'(bus.res_transport), 128'(2'd0));
    check("rst_cap", 128'(bus.res_cap), 128'(96'h0));
    check("rst_ovf", 128'(ovf_pulse), 128'(1'b0));
    check("rst_drop", 128'(drop_cnt), 128'(8'h00));
    rst_n = 1'b1;
    @(negedge clk);

    // L2 Sync: valid appears right after the edge that samples eof
    add_l2(8'h00, 8'h01);
    send(1'b1, 1'b1, 1'b0, 0, 1'b0, pv);
    check("l2_valid_before_eof", 128'(pv), 128'(1'b0));
    pop_expect("l2_sync", 4'h0, 2'd0, 96'h0102030405060708090A0B0C);
    check("l2_empty", 128'(bus.res_valid), 128'(1'b0));

    // QinQ + IPv4/UDP Delay_Req with an IP option, stalls every 3 bytes
    add_mac(); add16(16'h88A8); add16(16'h0064); add16(16'h8100); add16(16'h00C8);
    add16(16'h0800); add_ipv4(8'h11); add_udp(16'd319); add_ptp(8'h01, 8'h21);
    send(1'b1, 1'b1, 1'b0, 3, 1'b0, pv);
    pop_expect("qinq_v4", 4'h1, 2'd1, 96'h2122232425262728292A2B2C);

    // Third stacked tag exceeds VLAN_MAX
    add_mac(); add16(16'h88A8); add16(16'h0064); add16(16'h8100); add16(16'h00C8);
    add16(16'h8100); add16(16'h012C);
    add16(16'h0800); add_ipv4(8'h11); add_udp(16'd319); add_ptp(8'h01, 8'h21);
    send(1'b1, 1'b1, 1'b0, 0, 1'b0, pv);
    idle(2);
    check("three_tags_no_result", 128'(bus.res_valid), 128'(1'b0));

    // IPv4 carrying TCP is not PTP
    add_mac(); add16(16'h0800); add_ipv4(8'h06); add_udp(16'd319); add_ptp(8'h01, 8'h21);
    send(1'b1, 1'b1, 1'b0, 0, 1'b0, pv);
    idle(2);
    check("v4_tcp_no_result", 128'(bus.res_valid), 128'(1'b0));

    // IPv6 over two MPLS labels, general port
    add_mac(); add16(16'h8847); add_mpls(1'b0); add_mpls(1'b1);
    add_ipv6(); add_udp(16'd320); add_ptp(8'h08, 8'h41);
    send(1'b1, 1'b1, 1'b0, 0, 1'b0, pv);
    pop_expect("mpls_v6", 4'h8, 2'd2, 96'h4142434445464748494A4B4C);

    cfg_ipv6_en = 1'b0;
    add_mac(); add16(16'h8847); add_mpls(1'b0); add_mpls(1'b1);
    add_ipv6(); add_udp(16'd320); add_ptp(8'h08, 8'h41);
    send(1'b1, 1'b1, 1'b0, 0, 1'b0, pv);
    idle(2);
    check("v6_disabled_no_result", 128'(bus.res_valid), 128'(1'b0));
    cfg_ipv6_en = 1'b1;

    // Truncated at PTP byte 25 (frame byte 39)
    add_l2(8'h00, 8'h51);
    while (frame_q.size() > 40) void'(frame_q.pop_back());
    send(1'b1, 1'b1, 1'b0, 0, 1'b0, pv);
    idle(2);
    check("truncated_no_result", 128'(bus.res_valid), 128'(1'b0));

    // Complete frame flagged with rx_err
    add_l2(8'h00, 8'h51);
    send(1'b1, 1'b1, 1'b1, 0, 1'b0, pv);
    idle(2);
    check("rx_err_no_result", 128'(bus.res_valid), 128'(1'b0));

    // rx_sof at byte 40 restarts the parse
    add_l2(8'h00, 8'h51);
    while (frame_q.size() > 40) void'(frame_q.pop_back());
    send(1'b1, 1'b0, 1'b0, 0, 1'b0, pv);
    add_l2(8'h02, 8'h61);
    send(1'b1, 1'b1, 1'b0, 0, 1'b0, pv);
    pop_expect("restart", 4'h2, 2'd0, 96'h6162636465666768696A6B6C);
    check("restart_single_result", 128'(bus.res_valid), 128'(1'b0));

    // FIFO full: five back-to-back frames, consumer not ready
    for (int k = 0; k < 5; k++) begin
      add_l2(8'(k + 3), 8'h70 + 8'(16 * k));
      send(1'b1, 1'b1, 1'b0, 0, 1'b0, pv);
      if (k == 3) begin
        check("fill4_drop_cnt", 128'(drop_cnt), 128'(8'd0));
        check("fill4_ovf", 128'(ovf_pulse), 128'(1'b0));
      end
    end
    check("full_ovf_pulse", 128'(ovf_pulse), 128'(1'b1));
    check("full_drop_cnt", 128'(drop_cnt), 128'(8'd1));
    check("full_head_stable", 128'(bus.res_msg_type), 128'(4'h3));
    @(negedge clk);
    check("ovf_one_cycle", 128'(ovf_pulse), 128'(1'b0));

    // Sixth eof lands with res_ready high while full: pop and push together
    add_l2(8'h09, 8'hC0);
    send(1'b1, 1'b1, 1'b0, 0, 1'b1, pv);
    check("simul_drop_cnt", 128'(drop_cnt), 128'(8'd1));
    check("simul_ovf", 128'(ovf_pulse), 128'(1'b0));
    pop_expect("fifo_e2", 4'h4, 2'd0, exp_cap(8'h80));
    pop_expect("fifo_e3", 4'h5, 2'd0, exp_cap(8'h90));
    pop_expect("fifo_e4", 4'h6, 2'd0, exp_cap(8'hA0));
    pop_expect("fifo_e6", 4'h9, 2'd0, exp_cap(8'hC0));
    check("fifo_drained", 128'(bus.res_valid), 128'(1'b0));

    // Reset mid-capture with two entries queued
    add_l2(8'h0B, 8'h10);
    send(1'b1, 1'b1, 1'b0, 0, 1'b0, pv);
    add_l2(8'h0C, 8'h20);
    send(1'b1, 1'b1, 1'b0, 0, 1'b0, pv);
    add_l2(8'h0D, 8'h30);
    for (int i = 0; i < 8; i++) tail_q.push_front(frame_q.pop_back());
    send(1'b1, 1'b0, 1'b0, 0, 1'b0, pv);
    check("pre_reset_valid", 128'(bus.res_valid), 128'(1'b1));
    rst_n = 1'b0;
    #1;
    check("mid_reset_valid", 128'(bus.res_valid), 128'(1'b0));
    check("mid_reset_drop_cnt", 128'(drop_cnt), 128'(8'd0));
    check("mid_reset_cap", 128'(bus.res_cap), 128'(96'h0));
    @(negedge clk);
    rst_n = 1'b1;
    frame_q = tail_q;
    send(1'b0, 1'b1, 1'b0, 0, 1'b0, pv);
    idle(2);
    check("post_reset_ignored", 128'(bus.res_valid), 128'(1'b0));
    add_l2(8'h03, 8'hD0);
    send(1'b1, 1'b1, 1'b0, 0, 1'b0, pv);
    pop_expect("post_reset_frame", 4'h3, 2'd0, exp_cap(8'hD0));
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
